// File: rtl/message_expander_if.sv
// Handshake bundle between the message feeder, the SHA-256 schedule stage and compression.
// The slave modport is the expander's view; master is the upstream/downstream side.
interface message_expander_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 7
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] w_out;
  logic [IDX_WIDTH-1:0]  w_idx_out;
  logic                  w_valid_out;
  logic                  w_ready_in;
  logic                  done_out;

  modport master (
    output data_in, in_valid, w_ready_in,
    input  in_ready, w_out, w_idx_out, w_valid_out, done_out
  );

  modport slave (
    input  data_in, in_valid, w_ready_in,
    output in_ready, w_out, w_idx_out, w_valid_out, done_out
  );
endinterface

// File: rtl/message_expander.sv
// SHA-256 message schedule: loads 16 words into a shift register, then emits W[0..63].
// Optional build macro ME_BYTE_SWAP_EN byte-reverses each captured input word.
module message_expander #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 16,
  parameter int NUM_ROUNDS = 64
) (
  input logic               clk,
  input logic               rst,
  message_expander_if.slave bus
);
  localparam int CNT_W = $clog2(NUM_WORDS) + 1;
  localparam int IDX_W = $clog2(NUM_ROUNDS) + 1;

  typedef enum logic [1:0] {IDLE, LOAD, EXPAND, DONE} state_t;

  state_t                state_reg, state_next;
  logic [DATA_WIDTH-1:0] r_reg  [NUM_WORDS];
  logic [DATA_WIDTH-1:0] r_next [NUM_WORDS];
  logic [CNT_W-1:0]      word_cnt_reg, word_cnt_next;
  logic [IDX_W-1:0]      t_reg, t_next;

  logic                  in_ready, w_valid, done_pulse;
  logic                  in_accept, w_accept, shift_en;
  logic                  last_word, last_round;
  logic [DATA_WIDTH-1:0] captured_word, expanded_word;

  function automatic logic [DATA_WIDTH-1:0] rotr(input logic [DATA_WIDTH-1:0] x, input int n);
    return (x >> n) | (x << (DATA_WIDTH - n));
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma0(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sigma1(input logic [DATA_WIDTH-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

`ifdef ME_BYTE_SWAP_EN
  assign captured_word = {bus.data_in[7:0], bus.data_in[15:8],
                          bus.data_in[23:16], bus.data_in[31:24]};
`else
  assign captured_word = bus.data_in;
`endif

  assign in_accept  = bus.in_valid & in_ready;
  assign w_accept   = w_valid & bus.w_ready_in;
  assign shift_en   = in_accept | w_accept;
  assign last_word  = (word_cnt_reg == CNT_W'(NUM_WORDS - 1));
  assign last_round = (t_reg == IDX_W'(NUM_ROUNDS - 1));

  // With R[k] = W[t+k], the new tail word is W[t+16].
  assign expanded_word = sigma1(r_reg[NUM_WORDS-2]) + r_reg[NUM_WORDS-7]
                       + sigma0(r_reg[1]) + r_reg[0];

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_accept) state_next = LOAD;
      LOAD:    if (in_accept && last_word) state_next = EXPAND;
      EXPAND:  if (w_accept && last_round) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready   = 1'b0;
    w_valid    = 1'b0;
    done_pulse = 1'b0;
    case (state_reg)
      IDLE, LOAD: in_ready   = 1'b1;
      EXPAND:     w_valid    = 1'b1;
      DONE:       done_pulse = 1'b1;
      default:    in_ready   = 1'b0;
    endcase
  end

  // Loading and expanding both shift R down by one; only the tail source differs.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_WORDS - 1; gi++) begin : g_shift
      assign r_next[gi] = shift_en ? r_reg[gi+1] : r_reg[gi];
    end
  endgenerate

  assign r_next[NUM_WORDS-1] = in_accept ? captured_word :
                               w_accept  ? expanded_word : r_reg[NUM_WORDS-1];

  always_comb begin
    word_cnt_next = word_cnt_reg;
    t_next        = t_reg;
    if (in_accept) word_cnt_next = last_word ? '0 : word_cnt_reg + CNT_W'(1);
    if (w_accept)  t_next        = last_round ? '0 : t_reg + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_WORDS; i++) r_reg[i] <= '0;
      word_cnt_reg <= '0;
      t_reg        <= '0;
    end else begin
      for (int i = 0; i < NUM_WORDS; i++) r_reg[i] <= r_next[i];
      word_cnt_reg <= word_cnt_next;
      t_reg        <= t_next;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.w_out       = r_reg[0];
  assign bus.w_idx_out   = t_reg;
  assign bus.w_valid_out = w_valid;
  assign bus.done_out    = done_pulse;
endmodule
